// File: rtl/instr_encoder_loader.sv
// Boot-time program loader: encodes RV32I instruction descriptors (R-type, lw, sw, beq)
// and writes them to consecutive instruction-memory words from 0, holding the core in reset.
module instr_encoder_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_class,
  input  logic [2:0]            in_funct,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [12:0]           in_imm,
  input  logic                  in_last,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_rst,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  enc_err,
  output logic                  ovf_err
);

  typedef enum logic [1:0] {IDLE, ENCODE, WRITE, DONE} state_t;

  localparam logic [1:0] CLS_R      = 2'b00;
  localparam logic [1:0] CLS_LOAD   = 2'b01;
  localparam logic [1:0] CLS_STORE  = 2'b10;
  localparam logic [1:0] CLS_BRANCH = 2'b11;

  state_t      state, state_nxt;
  logic [1:0]  cls_q;
  logic [2:0]  funct_q;
  logic [4:0]  rd_q, rs1_q, rs2_q;
  logic [12:0] imm_q;
  logic        last_q;
  logic [31:0] word_q;
  logic [31:0] enc_word;
  logic        enc_legal;
  logic        mem_full;
  logic        accept;

  assign in_ready  = (state == IDLE) && rst;
  assign accept    = in_ready && in_valid;
  // The write pointer is the low bits of the word count; it only wraps after the final write.
  assign mem_full  = (count[ADDR_WIDTH-1:0] == {ADDR_WIDTH{1'b1}});
  assign imem_we   = (state == WRITE);
  assign imem_addr = count[ADDR_WIDTH-1:0];
  assign imem_wdata = word_q;
  assign done      = (state == DONE);
  assign core_rst  = (state == DONE);

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b0;
    case (cls_q)
      CLS_R: begin
        enc_legal = 1'b1;
        case (funct_q)
          3'b000:  enc_word = {7'b0000000, rs2_q, rs1_q, 3'b000, rd_q, 7'b0110011};
          3'b001:  enc_word = {7'b0100000, rs2_q, rs1_q, 3'b000, rd_q, 7'b0110011};
          3'b010:  enc_word = {7'b0000000, rs2_q, rs1_q, 3'b111, rd_q, 7'b0110011};
          3'b011:  enc_word = {7'b0000000, rs2_q, rs1_q, 3'b110, rd_q, 7'b0110011};
          3'b100:  enc_word = {7'b0000000, rs2_q, rs1_q, 3'b010, rd_q, 7'b0110011};
          default: enc_legal = 1'b0;
        endcase
      end
      CLS_LOAD: begin
        enc_legal = (imm_q[12] == imm_q[11]);
        enc_word  = {imm_q[11:0], rs1_q, 3'b010, rd_q, 7'b0000011};
      end
      CLS_STORE: begin
        enc_legal = (imm_q[12] == imm_q[11]);
        enc_word  = {imm_q[11:5], rs2_q, rs1_q, 3'b010, imm_q[4:0], 7'b0100011};
      end
      CLS_BRANCH: begin
        enc_legal = !imm_q[0];
        enc_word  = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, 3'b000, imm_q[4:1], imm_q[11],
                     7'b1100011};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ENCODE;
      ENCODE:  state_nxt = enc_legal ? WRITE : (last_q ? DONE : IDLE);
      WRITE:   state_nxt = (last_q || mem_full) ? DONE : IDLE;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cls_q   <= '0;
      funct_q <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
      last_q  <= 1'b0;
      word_q  <= '0;
      count   <= '0;
      enc_err <= 1'b0;
      ovf_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cls_q   <= in_class;
        funct_q <= in_funct;
        rd_q    <= in_rd;
        rs1_q   <= in_rs1;
        rs2_q   <= in_rs2;
        imm_q   <= in_imm;
        last_q  <= in_last;
      end
      if (state == ENCODE) begin
        if (enc_legal) word_q <= enc_word;
        else           enc_err <= 1'b1;
      end
      if (state == WRITE) begin
        count <= count + 1'b1;
        if (mem_full && !last_q) ovf_err <= 1'b1;
      end
    end
  end

endmodule
